// File: rtl/telemetry_pkg.sv
// Shared constants and types for the telemetry link receive path.
package telemetry_pkg;

  localparam logic [7:0] SYNC_BYTE     = 8'hA5;
  localparam logic [7:0] PAYLOAD_LEN   = 8'd8;
  localparam int         PAYLOAD_BYTES = 8;

  typedef enum logic [1:0] {
    HUNT,
    LEN,
    PAYLOAD,
    CHECK
  } frame_state_t;

  // Field order matches wire order, so the payload shift register maps straight onto it.
  typedef struct packed {
    logic [15:0] cpu_freq_mhz;
    logic [15:0] disk_speed_mbps;
    logic [15:0] memory_usage;
    logic [15:0] temperature_c;
  } telemetry_fields_t;

endpackage

// File: rtl/sat_counter.sv
// Event counter that saturates at all-ones; count updates the cycle after inc.
// No backpressure: inc is a single-cycle event strobe.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/telemetry_frame_decoder.sv
// Parses SYNC/LEN/8 payload/CHK frames from UART RX; fields and compute_enable update 1 cycle after CHK.
// No backpressure: every rx_valid byte is consumed; bad or stalled frames are dropped and counted.
module telemetry_frame_decoder
  import telemetry_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [15:0]      cpu_freq_mhz,
  output logic [15:0]      disk_speed_mbps,
  output logic [15:0]      memory_usage,
  output logic [15:0]      temperature_c,
  output logic             compute_enable,
  output logic             busy,
  output logic [CNT_W-1:0] frame_ok_cnt,
  output logic [CNT_W-1:0] chk_err_cnt,
  output logic [CNT_W-1:0] len_err_cnt,
  output logic [CNT_W-1:0] timeout_cnt
);

  localparam int              TO_W     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]      IDX_LAST = 3'(PAYLOAD_BYTES - 1);

  frame_state_t      state_q;
  frame_state_t      state_d;
  logic [2:0]        idx_q;
  logic [7:0]        xor_q;
  logic [TO_W-1:0]   timer_q;
  logic [63:0]       shadow_q;
  telemetry_fields_t fields_q;
  logic              compute_enable_q;

  logic timeout_hit;
  logic frame_good;
  logic chk_err;
  logic len_err;

  // A byte arriving in the final timeout cycle takes priority over the timeout.
  assign timeout_hit = (state_q != HUNT) && !rx_valid && (timer_q == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (timeout_hit) begin
      state_d = HUNT;
    end else if (rx_valid) begin
      case (state_q)
        HUNT:    if (rx_data == SYNC_BYTE) state_d = LEN;
        LEN:     state_d = (rx_data == PAYLOAD_LEN) ? PAYLOAD : HUNT;
        PAYLOAD: if (idx_q == IDX_LAST) state_d = CHECK;
        CHECK:   state_d = HUNT;
        default: state_d = HUNT;
      endcase
    end
  end

  always_comb begin
    frame_good = 1'b0;
    chk_err    = 1'b0;
    len_err    = 1'b0;
    busy       = (state_q != HUNT);
    if (rx_valid && (state_q == CHECK)) begin
      frame_good = (rx_data == xor_q);
      chk_err    = (rx_data != xor_q);
    end
    if (rx_valid && (state_q == LEN)) begin
      len_err = (rx_data != PAYLOAD_LEN);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q            <= '0;
      xor_q            <= '0;
      timer_q          <= '0;
      shadow_q         <= '0;
      fields_q         <= '0;
      compute_enable_q <= 1'b0;
    end else begin
      compute_enable_q <= frame_good;
      if (frame_good) begin
        fields_q <= shadow_q;
      end

      if ((state_q == HUNT) || rx_valid || timeout_hit) begin
        timer_q <= '0;
      end else begin
        timer_q <= timer_q + 1'b1;
      end

      // Payload shifts in MSB-first, so byte 0 lands in cpu_freq_mhz[15:8].
      if (rx_valid) begin
        case (state_q)
          LEN: begin
            xor_q <= rx_data;
            idx_q <= '0;
          end
          PAYLOAD: begin
            shadow_q <= {shadow_q[55:0], rx_data};
            xor_q    <= xor_q ^ rx_data;
            idx_q    <= idx_q + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign cpu_freq_mhz    = fields_q.cpu_freq_mhz;
  assign disk_speed_mbps = fields_q.disk_speed_mbps;
  assign memory_usage    = fields_q.memory_usage;
  assign temperature_c   = fields_q.temperature_c;
  assign compute_enable  = compute_enable_q;

  sat_counter #(.CNT_W(CNT_W)) u_frame_ok_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (frame_good),
    .count (frame_ok_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_chk_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (chk_err),
    .count (chk_err_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_len_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (len_err),
    .count (len_err_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_timeout_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (timeout_hit),
    .count (timeout_cnt)
  );

endmodule

// File: tb/tb_telemetry_frame_decoder.sv
// Directed bench: main decoder with 16-bit counters plus a 2-bit-counter copy on the same stream.
module tb_telemetry_frame_decoder;

  localparam int TO = 50;

  localparam logic [87:0] F1     = 88'hA5_08_0BB8_01F4_2000_0041_2F;
  localparam logic [87:0] F1_BAD = 88'hA5_08_0BB8_01F4_2000_0041_2E;
  localparam logic [87:0] FA     = 88'hA5_08_1388_0DAC_8000_004B_F9;
  localparam logic [87:0] FB     = 88'hA5_08_04B0_0064_0800_002D_FD;
  localparam logic [87:0] FC     = 88'hA5_08_09C4_00FA_1000_0032_1D;

  localparam logic [63:0] E1 = {16'd3000, 16'd500, 16'd8192, 16'd65};
  localparam logic [63:0] EA = {16'd5000, 16'd3500, 16'd32768, 16'd75};
  localparam logic [63:0] EB = {16'd1200, 16'd100, 16'd2048, 16'd45};
  localparam logic [63:0] EC = {16'd2500, 16'd250, 16'd4096, 16'd50};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;

  logic [15:0] cpu, disk, mem, temp;
  logic        ce, busy;
  logic [15:0] ok_cnt, chk_cnt, len_cnt, to_cnt;

  logic [15:0] cpu2, disk2, mem2, temp2;
  logic        ce2, busy2;
  logic [1:0]  ok2, chk2, len2, to2;

  int errors = 0;
  int checks = 0;
  logic [63:0] cap[$];

  always #5 clk = ~clk;

  telemetry_frame_decoder #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .cpu_freq_mhz(cpu), .disk_speed_mbps(disk), .memory_usage(mem), .temperature_c(temp),
    .compute_enable(ce), .busy(busy),
    .frame_ok_cnt(ok_cnt), .chk_err_cnt(chk_cnt), .len_err_cnt(len_cnt), .timeout_cnt(to_cnt)
  );

  telemetry_frame_decoder #(.TIMEOUT_CYCLES(TO), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .cpu_freq_mhz(cpu2), .disk_speed_mbps(disk2), .memory_usage(mem2), .temperature_c(temp2),
    .compute_enable(ce2), .busy(busy2),
    .frame_ok_cnt(ok2), .chk_err_cnt(chk2), .len_err_cnt(len2), .timeout_cnt(to2)
  );

  // Record the field snapshot on every compute_enable pulse.
  always @(negedge clk) begin
    if (ce) cap.push_back({cpu, disk, mem, temp});
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
  endtask

  task automatic stop();
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_bytes(input logic [87:0] f, input int first, input int n);
    for (int i = first; i < first + n; i++) send(f[87-8*i -: 8]);
  endtask

  task automatic send_frame(input logic [87:0] f);
    send_bytes(f, 0, 11);
  endtask

  function automatic logic [63:0] fields();
    return {cpu, disk, mem, temp};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_fields", fields(), 64'h0);
    check("reset_ce", ce, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_cnts", {ok_cnt, chk_cnt, len_cnt, to_cnt}, 64'h0);

    // 1: good frame, pulse visible the cycle after CHK and only for one cycle
    send_frame(F1);
    stop();
    check("t1_ce_high", ce, 1'b1);
    check("t1_fields", fields(), E1);
    @(negedge clk);
    check("t1_ce_low", ce, 1'b0);
    check("t1_ok_cnt", ok_cnt, 16'd1);
    check("t1_pulses", cap.size(), 1);

    // 2: checksum failure leaves fields alone
    send_frame(F1_BAD);
    stop();
    check("t2_ce", ce, 1'b0);
    @(negedge clk);
    check("t2_chk_cnt", chk_cnt, 16'd1);
    check("t2_fields", fields(), E1);
    check("t2_pulses", cap.size(), 1);

    // 3: garbage then bad LEN; then a LEN byte equal to SYNC is not re-taken as SYNC
    send(8'h00); send(8'hFF); send(8'hA5); send(8'h07);
    stop();
    check("t3_len_cnt", len_cnt, 16'd1);
    check("t3_busy", busy, 1'b0);
    send(8'hA5); send(8'hA5);
    send_bytes(FC, 1, 10);
    stop();
    @(negedge clk);
    check("t3_sync_reexam_len", len_cnt, 16'd2);
    check("t3_sync_reexam_pulses", cap.size(), 1);
    check("t3_busy2", busy, 1'b0);
    send_frame(FC);
    stop();
    check("t3_fields_c", fields(), EC);
    check("t3_ok_cnt", ok_cnt, 16'd2);

    // 4: stall after four payload bytes
    send_bytes(FA, 0, 6);
    stop();
    repeat (40) @(negedge clk);
    check("t4_busy_before", busy, 1'b1);
    check("t4_to_before", to_cnt, 16'd0);
    repeat (20) @(negedge clk);
    check("t4_to_cnt", to_cnt, 16'd1);
    check("t4_busy_after", busy, 1'b0);
    check("t4_fields", fields(), EC);

    // 4b: next byte lands exactly in the last timeout cycle and wins
    send_bytes(FB, 0, 6);
    stop();
    repeat (48) @(negedge clk);
    send_bytes(FB, 6, 5);
    stop();
    check("t4b_to_cnt", to_cnt, 16'd1);
    check("t4b_ce", ce, 1'b1);
    check("t4b_fields", fields(), EB);

    // 5: back-to-back frames
    send_frame(FA);
    send_frame(FB);
    stop();
    @(negedge clk);
    check("t5_pulses", cap.size(), 5);
    check("t5_cap_a", cap[3], EA);
    check("t5_cap_b", cap[4], EB);
    check("t5_ok_cnt", ok_cnt, 16'd5);
    check("t5_sat_ok", ok2, 2'd3);

    // 6: reset mid-payload
    send_bytes(FA, 0, 5);
    @(negedge clk);
    rx_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_fields", fields(), 64'h0);
    check("t6_cnts", {ok_cnt, chk_cnt, len_cnt, to_cnt}, 64'h0);
    check("t6_busy_ce", {busy, ce}, 2'b00);
    send_frame(F1);
    stop();
    check("t6_ce", ce, 1'b1);
    check("t6_fields_after", fields(), E1);
    check("t6_ok_cnt", ok_cnt, 16'd1);

    // saturation: five bad checksums on the 2-bit copy
    for (int k = 0; k < 5; k++) send_frame(F1_BAD);
    stop();
    @(negedge clk);
    check("sat_chk_wide", chk_cnt, 16'd5);
    check("sat_chk_narrow", chk2, 2'd3);
    check("sat_ok_narrow", ok2, 2'd1);
    check("sat_pulses", cap.size(), 6);
    check("sat_fields", {cpu2, disk2, mem2, temp2}, E1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
